// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store memory front-end.
// Holds the bus widths, the maximum read-burst length, the controller
// state encoding and the request-length clamp used at accept time.
package mem_ctrl_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 3;
  localparam int MAX_BURST = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DRAIN = 3'd2,
    WR_ISSUE = 3'd3,
    WR_ACK   = 3'd4
  } state_t;

  // A zero length still means one beat; anything above MAX_BURST is cut
  // down to MAX_BURST.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] eff;
    if (len == '0)
      eff = LEN_W'(1);
    else if (len > LEN_W'(MAX_BURST))
      eff = LEN_W'(MAX_BURST);
    else
      eff = len;
    return eff;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the request, memory and response signals of mem_access_ctrl.
// Ports (by group):
//   request : req_valid, req_ready, req_we, req_addr, req_wdata, req_len
//   memory  : mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_rdata
//   response: rsp_valid, rsp_data, rsp_last, plus busy status
// The slave modport is the controller's view; master is the view of the
// datapath/memory environment around it.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;

  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
    output req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata,
           rsp_valid, rsp_data, rsp_last, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
    input  req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata,
           rsp_valid, rsp_data, rsp_last, busy
  );

endinterface

// File: rtl/mem_beat_counter.sv
// Address/length bookkeeping for a read burst.
// Ports:
//   clk, rst    : clock, async active-high reset
//   load        : request accepted; start_addr/len describe the burst
//   advance     : one more beat is being issued this cycle
//   start_addr  : first beat address (issued directly by the FSM)
//   len         : clamped beat count (1..MAX_BURST)
//   beat_addr   : address of the next beat still to issue
//   beat_last   : the next beat to issue is the final one
//   beat_done   : every beat of the burst has been issued
module mem_beat_counter
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              beat_last,
  output logic              beat_done
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;

  // The first beat leaves on the accept edge itself, so the counter starts
  // one address ahead and one beat short. Address arithmetic wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (load) begin
      addr_q    <= start_addr + ADDR_W'(1);
      remaining <= len - LEN_W'(1);
    end else if (advance) begin
      addr_q    <= addr_q + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign beat_addr = addr_q;
  assign beat_last = (remaining == LEN_W'(1));
  assign beat_done = (remaining == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end between the datapath and an 8-bit synchronous
// memory with one cycle of read latency.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : mem_access_ctrl_if.slave carrying the request handshake
//              (req_*), memory drive/return (mem_*), the tagged response
//              stream (rsp_*) and busy
// Writes take one memory cycle and return a zero-data ack; reads issue
// 1..MAX_BURST consecutive addresses and return one response per beat.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  state_t            state;
  logic              accept;
  logic [LEN_W-1:0]  eff_len;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;
  logic              beat_done;
  logic              mem_last;
  logic              d_valid;
  logic              d_last;

  assign accept  = bus.req_valid & bus.req_ready;
  assign eff_len = clamp_len(bus.req_len);

  mem_beat_counter u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept & ~bus.req_we),
    .advance    ((state == RD_ISSUE) & ~beat_done),
    .start_addr (bus.req_addr),
    .len        (eff_len),
    .beat_addr  (beat_addr),
    .beat_last  (beat_last),
    .beat_done  (beat_done)
  );

  assign bus.busy = (state != IDLE);

  // Controller FSM plus response pipeline. A read beat flows issue
  // (mem_read_en) -> data (d_valid, memory output valid) -> response
  // (rsp_valid), with its last flag carried alongside. The write ack is
  // injected into the response stage while in WR_ISSUE. The drain ends
  // once the final beat sits in the response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.req_ready    <= 1'b0;
      bus.mem_read_en  <= 1'b0;
      bus.mem_write_en <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_last     <= 1'b0;
      mem_last         <= 1'b0;
      d_valid          <= 1'b0;
      d_last           <= 1'b0;
    end else begin
      d_valid       <= bus.mem_read_en;
      d_last        <= bus.mem_read_en & mem_last;
      bus.rsp_valid <= d_valid | (state == WR_ISSUE);
      bus.rsp_last  <= (d_valid & d_last) | (state == WR_ISSUE);
      bus.rsp_data  <= d_valid ? bus.mem_rdata : '0;

      case (state)
        IDLE: begin
          bus.mem_read_en  <= 1'b0;
          bus.mem_write_en <= 1'b0;
          bus.mem_addr     <= '0;
          bus.mem_wdata    <= '0;
          mem_last         <= 1'b0;
          bus.req_ready    <= 1'b1;
          if (accept) begin
            bus.req_ready <= 1'b0;
            bus.mem_addr  <= bus.req_addr;
            if (bus.req_we) begin
              state            <= WR_ISSUE;
              bus.mem_write_en <= 1'b1;
              bus.mem_wdata    <= bus.req_wdata;
            end else begin
              state           <= RD_ISSUE;
              bus.mem_read_en <= 1'b1;
              mem_last        <= (eff_len == LEN_W'(1));
            end
          end
        end
        RD_ISSUE: begin
          if (beat_done) begin
            state           <= RD_DRAIN;
            bus.mem_read_en <= 1'b0;
            bus.mem_addr    <= '0;
            mem_last        <= 1'b0;
          end else begin
            bus.mem_read_en <= 1'b1;
            bus.mem_addr    <= beat_addr;
            mem_last        <= beat_last;
          end
        end
        RD_DRAIN: begin
          if (bus.rsp_last) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        WR_ISSUE: begin
          state            <= WR_ACK;
          bus.mem_write_en <= 1'b0;
          bus.mem_addr     <= '0;
          bus.mem_wdata    <= '0;
        end
        WR_ACK: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: requests push expected memory
// operations, response beats and ready-rise cycles; independent monitors
// pop and compare them. Includes a byte-array memory with one-cycle read
// latency and a reference memory image updated at request time.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } mem_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int       ready_q[$];

  logic [7:0] ref_mem [256];
  logic [7:0] ram [256];
  logic [7:0] mem_dout;
  bit         mem_init_done = 1'b0;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: ram[n] = n at start, one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
      mem_init_done <= 1'b1;
    end else begin
      if (bus.mem_read_en) mem_dout <= ram[bus.mem_addr];
      if (bus.mem_write_en) ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem_dout;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  // Present one request, wait (bounded) for the handshake, record what the
  // reference model says must follow. Called and returns on a falling edge.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [2:0] len, input bit keep, output int hs_cyc);
    bit         got;
    int         eff;
    logic [7:0] a;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    got    = 1'b0;
    hs_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      reportFail("handshake_timeout");
    end else begin
      hs_cyc = cyc;
      if (we) begin
        ref_mem[addr] = wdata;
        mem_q.push_back('{1'b1, addr, wdata, hs_cyc + 1});
        rsp_q.push_back('{8'h00, 1'b1, hs_cyc + 2});
        ready_q.push_back(hs_cyc + 3);
      end else begin
        eff = (len == 0) ? 1 : ((int'(len) > 4) ? 4 : int'(len));
        for (int k = 0; k < eff; k++) begin
          a = addr + 8'(k);
          mem_q.push_back('{1'b0, a, 8'h00, hs_cyc + 1 + k});
          rsp_q.push_back('{ref_mem[a], (k == eff - 1), hs_cyc + 3 + k});
        end
        ready_q.push_back(hs_cyc + eff + 3);
      end
    end
    @(negedge clk);
    if (got) checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic monitorMem();
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("rd_wr_exclusive", 32'(bus.mem_read_en & bus.mem_write_en), 32'd0);
        if (!bus.mem_write_en) checkOutput("wdata_idle", 32'(bus.mem_wdata), 32'd0);
        if (bus.mem_read_en || bus.mem_write_en) begin
          if (mem_q.size() == 0) begin
            reportFail("mem_unexpected");
          end else begin
            e = mem_q.pop_front();
            checkOutput("mem_we", 32'(bus.mem_write_en), 32'(e.we));
            checkOutput("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            if (e.we) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            checkOutput("mem_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else begin
          checkOutput("addr_idle", 32'(bus.mem_addr), 32'd0);
        end
      end
    end
  endtask

  task automatic monitorRsp();
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          reportFail("rsp_unexpected");
        end else begin
          e = rsp_q.pop_front();
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          checkOutput("rsp_last", 32'(bus.rsp_last), 32'(e.last));
          checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (!rst) begin
        checkOutput("rsp_last_idle", 32'(bus.rsp_last), 32'd0);
      end
    end
  endtask

  task automatic monitorReady();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) checkOutput("busy_when_ready", 32'(bus.busy), 32'd0);
      if (bus.req_ready && !prev) begin
        if (ready_q.size() == 0) reportFail("ready_unexpected");
        else checkOutput("ready_cycle", 32'(cyc), 32'(ready_q.pop_front()));
      end
      prev = bus.req_ready;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, "_mem_read_en"}, 32'(bus.mem_read_en), 32'd0);
    checkOutput({tag, "_mem_write_en"}, 32'(bus.mem_write_en), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    checkOutput({tag, "_rsp_last"}, 32'(bus.rsp_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int hs0;
    int hs1;
    bit keep;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;

    fork
      monitorMem();
      monitorRsp();
      monitorReady();
    join_none

    #1 rst = 1'b1;
    #1 checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ready_q.push_back(cyc + 1);
    @(negedge clk);

    $display("[TB] directed reads and write");
    applyStimulus(1'b0, 8'd5, 8'h00, 3'd1, 1'b0, hs0);
    applyStimulus(1'b0, 8'd12, 8'h00, 3'd4, 1'b0, hs0);
    applyStimulus(1'b0, 8'd255, 8'h00, 3'd0, 1'b0, hs0);
    applyStimulus(1'b0, 8'd254, 8'h00, 3'd7, 1'b0, hs0);
    applyStimulus(1'b1, 8'd20, 8'hAA, 3'd0, 1'b0, hs0);
    applyStimulus(1'b0, 8'd20, 8'h00, 3'd1, 1'b0, hs0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b0, 8'd1, 8'h00, 3'd4, 1'b0, hs0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("midreset");
    mem_q.delete();
    rsp_q.delete();
    ready_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_q.push_back(cyc + 1);
    @(negedge clk);
    applyStimulus(1'b0, 8'd3, 8'h00, 3'd1, 1'b0, hs0);

    $display("[TB] back-to-back read then write");
    applyStimulus(1'b0, 8'd40, 8'h00, 3'd2, 1'b1, hs0);
    applyStimulus(1'b1, 8'd41, 8'h33, 3'd0, 1'b0, hs1);
    checkOutput("b2b_spacing", 32'(hs1 - hs0), 32'd5);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      keep = ($urandom_range(0, 3) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    3'($urandom_range(0, 7)), keep, hs0);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;

    repeat (20) @(negedge clk);
    checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
    checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    checkOutput("ready_q_drained", 32'(ready_q.size()), 32'd0);
    checkOutput("final_ready", 32'(bus.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store front-end between the processor datapath and the 8-bit synchronous data memory. It accepts single-beat write requests and read requests of 1..MAX_BURST beats over a valid/ready handshake. It drives the memory's read enable, address and write-data bus (plus a write-enable strobe), and tracks the memory's 1-cycle read latency. Returned bytes go back to the datapath as a tagged response stream with a last-beat flag.

Parameters:
ADDR_W, 8, width of memory address and request address
DATA_W, 8, width of data bytes
LEN_W, 3, width of req_len field
MAX_BURST, 4, maximum read beats per request; larger req_len is clamped

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle and able to accept
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  start address
req_wdata  in  DATA_W  write byte (ignored for reads)
req_len  in  LEN_W  read beat count; 0 treated as 1; ignored for writes
mem_read_en  out  1  to memory read_en
mem_write_en  out  1  to memory write strobe
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory datain
mem_rdata  in  DATA_W  from memory dataout (valid the cycle after read_en/addr were sampled)
rsp_valid  out  1  response beat valid (no backpressure)
rsp_data  out  DATA_W  read byte, 0 for write ack
rsp_last  out  1  final beat of the current request
busy  out  1  not IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, including req_ready. In-flight beats are discarded. req_ready rises on the first clk edge with rst=0.
- Accept: a handshake occurs on the edge where req_valid & req_ready = 1. That edge (E0) latches addr, wdata and the effective length L = clamp(max(req_len,1), MAX_BURST). req_ready drops at E0.
- All mem_* and rsp_* outputs are registered.
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, WR_ACK.
- Read, L beats:
  - Cycles 1..L: RD_ISSUE, mem_read_en=1, mem_addr = A+k (k=0..L-1, mod 2^ADDR_W, so 255 wraps to 0).
  - Cycles L+1..L+2: RD_DRAIN, mem_read_en=0, mem_addr=0.
  - mem_rdata for beat k is valid in cycle k+2 and is registered onto rsp_data with rsp_valid=1 in cycle k+3.
  - rsp_last=1 only in cycle L+2.
  - State is IDLE and req_ready=1 from cycle L+3.
- Beat tracking: a 2-stage valid shift register (issue → data → response), plus a "last" bit carried alongside.
- Write:
  - Cycle 1: WR_ISSUE, mem_write_en=1, mem_addr=A, mem_wdata=D.
  - Cycle 2: WR_ACK, rsp_valid=1, rsp_last=1, rsp_data=0.
  - IDLE from cycle 3.
- Idle levels: mem_write_en is never high in the same cycle as mem_read_en. mem_wdata=0 outside WR_ISSUE.
- Back-to-back: a req_valid held high is accepted on the first edge of the IDLE cycle. Minimum read-to-read spacing is L+3 cycles.
- busy = (state != IDLE). req_ready = registered (state == IDLE) & ~rst.
- Simultaneous events: rst dominates the clock. Requests arriving while req_ready=0 are not latched; the requester must hold req_valid.

Decomposition:
- Package mem_ctrl_pkg holds: ADDR_W/DATA_W/LEN_W defaults, the MAX_BURST constant, the FSM state enum (3-bit encoding), and the length-clamp function.
- One sub-module, mem_beat_counter, handles the beat address increment, the remaining-beats down-counter and last-issue detection.
- The FSM and the response pipeline stay in the top module.

Test Plan:
1. Single read, memory preloaded ram[n]=n: req addr=5, len=1, at E0 → mem_read_en=1/mem_addr=5 in cycle 1; rsp_valid=1, rsp_data=5, rsp_last=1 in cycle 3; req_ready=1 in cycle 4.
2. Burst read: addr=12, len=4 → mem_addr 12,13,14,15 in cycles 1-4; rsp_data 12,13,14,15 in cycles 3-6; rsp_last only in cycle 6.
3. Length clamp and wrap: addr=255, len=0 → one beat at address 255. addr=254, len=7 → 4 beats at mem_addr 254,255,0,1, and 4 rsp_valid pulses.
4. Write: addr=20, wdata=0xAA → cycle 1: mem_write_en=1, mem_addr=20, mem_wdata=0xAA, mem_read_en=0; cycle 2: rsp_valid=1, rsp_last=1, rsp_data=0.
5. Reset mid-burst: addr=1, len=4, rst asserted asynchronously in cycle 2 → all outputs 0 immediately, no further rsp_valid. After release, req_ready=1 one edge later and a new read of addr=3 returns 3.
6. Back-to-back: req_valid held with read len=2 then write → second handshake at cycle 5, no overlap of mem_read_en and mem_write_en, and exactly 3 rsp_valid pulses total.
